mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- CPU-side initiator of the byte-serial system memory bus: mem_a / mem_wr / mem_dout out, mem_din in.
- Serves two internal clients: instruction fetch (read-only, 4 bytes) and load/store unit (1/2/4 bytes, read or write).
- Converts each word or halfword request into consecutive byte accesses, little-endian.
- Honours the RAM's 1-cycle read latency and the rdy_in pause used when the host interface takes over the bus.

Parameters:
- ADDR_W, 32, width of mem_a and client addresses.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  1 = bus owned by CPU; 0 = paused (host owns bus)
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  1-cycle pulse, if_data valid
- if_data  out  32  fetched word
- ls_req  in  1  load/store request, level, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = reserved (treated as 4B)
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, byte 0 = [7:0]
- ls_done  out  1  1-cycle pulse
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  read data; valid the cycle after the address is presented
- mem_dout  out  8  write data
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write this cycle

Behaviour:
- Reset (async): state IDLE; mem_a = 0, mem_wr = 0, mem_dout = 0, if_done = ls_done = 0, if_data = ls_rdata = 0.
- Reset mid-transaction: the transaction is abandoned and mem_wr drops immediately. Bytes already written stay written.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples requests; ls_req has priority over if_req.
  - On acceptance, latches client id, we, byte count N (1/2/4), addr, wdata.
  - Enters READ or WRITE. mem_a = 0 and mem_wr = 0 while IDLE.
- READ, with rdy_in high; cycle k = k-th cycle after the accepting edge:
  - Cycles 1..N: mem_a = addr + (k-1).
  - Byte i is captured from mem_din at the edge ending cycle i+2, into result bits [8i+7:8i].
  - Cycle N+1: mem_a = 0.
  - Done pulse in cycle N+2. Word read = 6 cycles, byte read = 3 cycles.
- WRITE, cycles 1..N: mem_a = addr + (k-1), mem_dout = wdata byte (k-1), mem_wr = 1. Done pulse in cycle N+1.
- DONE:
  - The matching done output is 1 for exactly one cycle; the data output is stable from this cycle until the next done for that client.
  - Next state is IDLE. Requests are not sampled in DONE, so the client deasserts req during the done cycle.
- Address arithmetic: addr + i is modulo 2^32 (0xFFFFFFFF + 1 = 0). Unaligned addresses are legal.
- Unused high bytes of ls_rdata / if_data are 0. There is no sign extension.
- rdy_in = 0:
  - Entire state frozen; mem_wr forced to 0; done pulses not emitted (a pending DONE is held).
  - mem_din during the pause and in the first cycle after it is ignored.
  - On resume, READ re-presents the address of the first uncaptured byte (one extra cycle). WRITE re-issues the first unwritten byte.
  - Each byte is written exactly once and each IO address is read exactly once per transaction.
- Requests arriving while busy wait. A request held in IDLE with rdy_in = 0 is not accepted.

Test Plan:
- Reset: assert rst_in mid-cycle with mem_wr = 1 -> mem_wr = 0 asynchronously; all outputs 0; state IDLE.
- Fetch: RAM[0x1000..0x1003] = 11 22 33 44, if_req at 0x1000 -> mem_a 1000, 1001, 1002, 1003; if_data = 0x44332211; if_done in cycle 6 only.
- Halfword store: ls_we = 1, size = 1, addr = 0x2001, wdata = 0x0000ABCD -> mem_wr high 2 cycles writing CD@0x2001 then AB@0x2002; ls_done cycle 3; byte load at 0x2002 returns 0x000000AB.
- Arbitration: if_req and ls_req rise together (ls load 4B at 0x3000) -> ls served first (ls_done cycle 6); fetch accepted in the IDLE after DONE.
- Pause: word load at 0x1000, rdy_in low for 3 cycles after byte 1 is captured -> mem_wr 0 throughout; result 0x44332211; ls_done delayed exactly 4 cycles versus no pause.
- Wrap/IO: store 4B at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1. Byte store 0x41 at 0x00030000 -> exactly one mem_wr cycle at that address.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Signal bundle between mem_ctrl, its fetch/load-store clients and the
// byte-serial system RAM. The controller takes the master view.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rdy_in;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport master (
        input  rdy_in, if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        output rdy_in, if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory bus initiator: splits fetch and load/store requests into
// little-endian byte accesses, honouring 1-cycle read latency and rdy_in pauses.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    mem_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic              r_cli;      // 1 = load/store, 0 = fetch
    logic [2:0]        r_n;
    logic [2:0]        r_ai;       // next byte whose address is presented
    logic [2:0]        r_ci;       // next byte to capture
    logic              r_pend;     // mem_din this cycle belongs to byte r_ci
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic [31:0]       r_if_data;
    logic [31:0]       r_ls_rdata;

    logic [ADDR_W-1:0] w_byte_addr;
    logic              w_issue;
    logic              w_last_cap;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_data_cap;
    logic [2:0]        w_req_n;
    logic              w_rd_a;
    logic              w_wr;

    assign w_byte_addr = r_addr + ADDR_W'(r_ai);
    assign w_issue     = (r_ai < r_n);
    assign w_last_cap  = r_pend && (r_ci == r_n - 3'd1);
    assign w_wbyte     = r_wdata[{r_ai[1:0], 3'b000} +: 8];

    always_comb begin
        w_data_cap = r_data;
        w_data_cap[{r_ci[1:0], 3'b000} +: 8] = bus.mem_din;
    end

    always_comb begin
        case (bus.ls_size)
            2'd0:    w_req_n = 3'd1;
            2'd1:    w_req_n = 3'd2;
            default: w_req_n = 3'd4;
        endcase
    end

    // The host owns the bus while rdy_in is low, so the address is withdrawn too.
    assign w_rd_a = bus.rdy_in && (r_state == S_READ) && w_issue;
    assign w_wr   = bus.rdy_in && (r_state == S_WRITE);

    assign bus.mem_a    = (w_rd_a || w_wr) ? w_byte_addr : '0;
    assign bus.mem_wr   = w_wr;
    assign bus.mem_dout = w_wr ? w_wbyte : 8'h00;
    assign bus.if_done  = bus.rdy_in && (r_state == S_DONE) && !r_cli;
    assign bus.ls_done  = bus.rdy_in && (r_state == S_DONE) && r_cli;
    assign bus.if_data  = r_if_data;
    assign bus.ls_rdata = r_ls_rdata;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cli      <= 1'b0;
            r_n        <= 3'd0;
            r_ai       <= 3'd0;
            r_ci       <= 3'd0;
            r_pend     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_data     <= 32'h0;
            r_if_data  <= 32'h0;
            r_ls_rdata <= 32'h0;
        end else if (!bus.rdy_in) begin
            // Rewind to the first uncaptured byte; data in flight is discarded.
            if (r_state == S_READ) begin
                r_ai   <= r_ci;
                r_pend <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ls_req || bus.if_req) begin
                        r_cli   <= bus.ls_req;
                        r_n     <= bus.ls_req ? w_req_n : 3'd4;
                        r_addr  <= bus.ls_req ? bus.ls_addr : bus.if_addr;
                        r_wdata <= bus.ls_wdata;
                        r_ai    <= 3'd0;
                        r_ci    <= 3'd0;
                        r_pend  <= 1'b0;
                        r_data  <= 32'h0;
                        r_state <= (bus.ls_req && bus.ls_we) ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    if (r_pend) begin
                        r_data <= w_data_cap;
                        r_ci   <= r_ci + 3'd1;
                    end
                    if (w_issue)
                        r_ai <= r_ai + 3'd1;
                    r_pend <= w_issue;
                    if (w_last_cap) begin
                        r_state <= S_DONE;
                        if (r_cli)
                            r_ls_rdata <= w_data_cap;
                        else
                            r_if_data <= w_data_cap;
                    end
                end
                S_WRITE: begin
                    r_ai <= r_ai + 3'd1;
                    if (r_ai == r_n - 3'd1)
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, table of transactions with
// hand-computed results, plus hand-written multi-cycle corner sequences.
module tb_mem_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus.master)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: 1-cycle read latency, backdoor port for preloading.
    logic [7:0]  ram [0:262143];
    logic        bd_we = 1'b0;
    logic [31:0] bd_a  = 32'h0;
    logic [7:0]  bd_d  = 8'h0;

    always @(posedge clk_in) begin
        bus.mem_din <= ram[bus.mem_a[17:0]];
        if (bd_we)
            ram[bd_a[17:0]] <= bd_d;
        else if (bus.mem_wr)
            ram[bus.mem_a[17:0]] <= bus.mem_dout;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] tr_a[$];
    logic        tr_wr[$];
    logic [7:0]  tr_dout[$];

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_cyc;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        bd_a  = a;
        bd_d  = d;
        bd_we = 1'b1;
        @(negedge clk_in);
        bd_we = 1'b0;
    endtask

    // Called in an IDLE cycle just after a negedge; returns one cycle after done.
    task automatic run(input bit is_if, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int p_start, input int p_len,
                       output logic [31:0] data, output int cyc);
        logic done;
        tr_a.delete();
        tr_wr.delete();
        tr_dout.delete();
        cyc  = 0;
        done = 1'b0;
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.ls_req   = 1'b1;
            bus.ls_we    = we;
            bus.ls_size  = size;
            bus.ls_addr  = addr;
            bus.ls_wdata = wdata;
        end
        while (!done && cyc < 40) begin
            @(posedge clk_in);
            @(negedge clk_in);
            cyc++;
            if (p_len > 0 && cyc == p_start) bus.rdy_in = 1'b0;
            if (p_len > 0 && cyc == p_start + p_len) bus.rdy_in = 1'b1;
            #1;
            tr_a.push_back(bus.mem_a);
            tr_wr.push_back(bus.mem_wr);
            tr_dout.push_back(bus.mem_dout);
            done = is_if ? bus.if_done : bus.ls_done;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        data = is_if ? bus.if_data : bus.ls_rdata;
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        bus.rdy_in = 1'b1;
        @(negedge clk_in);
        #1;
        chk("done_one_cycle", 32'(is_if ? bus.if_done : bus.ls_done), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          c;
        int          nwr;
        int          ls_c;
        int          if_c;

        vt[0] = '{0, 0, 2'd1, 32'h0000_2001, 32'h0,         32'h0000_ABCD, 4};
        vt[1] = '{0, 0, 2'd2, 32'h0000_1001, 32'h0,         32'h5544_3322, 6};
        vt[2] = '{0, 0, 2'd3, 32'h0000_1000, 32'h0,         32'h4433_2211, 6};
        vt[3] = '{0, 1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0,         5};
        vt[4] = '{0, 0, 2'd2, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 6};
        vt[5] = '{0, 0, 2'd0, 32'h0000_3003, 32'h0,         32'h0000_00DE, 3};
        vt[6] = '{1, 0, 2'd0, 32'h0000_1001, 32'h0,         32'h5544_3322, 6};
        vt[7] = '{0, 1, 2'd0, 32'h0000_2003, 32'hFFFF_FF77, 32'h0,         2};
        vt[8] = '{0, 0, 2'd2, 32'h0000_2000, 32'h0,         32'h77AB_CD99, 6};
        vt[9] = '{0, 0, 2'd1, 32'h0000_1003, 32'h0,         32'h0000_5544, 4};

        bus.rdy_in   = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_size  = 2'd0;
        bus.ls_addr  = 32'h0;
        bus.ls_wdata = 32'h0;

        poke(32'h1000, 8'h11); poke(32'h1001, 8'h22); poke(32'h1002, 8'h33);
        poke(32'h1003, 8'h44); poke(32'h1004, 8'h55); poke(32'h2000, 8'h99);
        poke(32'h3000, 8'hA1); poke(32'h3001, 8'hB2); poke(32'h3002, 8'hC3);
        poke(32'h3003, 8'hD4);

        #1;
        chk("rst_mem_a",    bus.mem_a,          32'h0);
        chk("rst_mem_wr",   32'(bus.mem_wr),    32'h0);
        chk("rst_mem_dout", 32'(bus.mem_dout),  32'h0);
        chk("rst_dones",    32'({bus.if_done, bus.ls_done}), 32'h0);
        chk("rst_if_data",  bus.if_data,        32'h0);
        chk("rst_ls_rdata", bus.ls_rdata,       32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;

        // Fetch 0x1000: addresses, data, done in cycle 6.
        run(1, 0, 2'd2, 32'h1000, 32'h0, 0, 0, d, c);
        chk("fetch_cyc",  32'(c), 32'd6);
        chk("fetch_data", d, 32'h4433_2211);
        for (int i = 0; i < 4; i++) chk("fetch_addr", tr_a[i], 32'h1000 + 32'(i));
        chk("fetch_addr_idle", tr_a[4], 32'h0);

        // Halfword store 0xABCD at 0x2001.
        run(0, 1, 2'd1, 32'h2001, 32'h0000_ABCD, 0, 0, d, c);
        chk("hst_cyc",   32'(c), 32'd3);
        chk("hst_wr",    32'({tr_wr[0], tr_wr[1], tr_wr[2]}), 32'b110);
        chk("hst_a0",    tr_a[0], 32'h2001);
        chk("hst_d0",    32'(tr_dout[0]), 32'hCD);
        chk("hst_a1",    tr_a[1], 32'h2002);
        chk("hst_d1",    32'(tr_dout[1]), 32'hAB);

        run(0, 0, 2'd0, 32'h2002, 32'h0, 0, 0, d, c);
        chk("bld_cyc",  32'(c), 32'd3);
        chk("bld_data", d, 32'h0000_00AB);

        // Arbitration: both requests rise together, load/store wins.
        bus.ls_req  = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h3000;
        bus.if_req  = 1'b1; bus.if_addr = 32'h1000;
        ls_c = 0;
        if_c = 0;
        for (int k = 1; k <= 30 && if_c == 0; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            #1;
            if (bus.ls_done) begin
                ls_c = k;
                chk("arb_ls_data", bus.ls_rdata, 32'hD4C3_B2A1);
                bus.ls_req = 1'b0;
            end
            if (bus.if_done) begin
                if_c = k;
                chk("arb_if_data", bus.if_data, 32'h4433_2211);
                bus.if_req = 1'b0;
            end
        end
        chk("arb_ls_cyc", 32'(ls_c), 32'd6);
        chk("arb_if_cyc", 32'(if_c), 32'd13);
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk_in);
        #1;

        // Pause for three edges after byte 1 is captured.
        run(0, 0, 2'd2, 32'h1000, 32'h0, 4, 3, d, c);
        chk("pause_cyc",  32'(c), 32'd10);
        chk("pause_data", d, 32'h4433_2211);
        nwr = 0;
        foreach (tr_wr[i]) nwr += int'(tr_wr[i]);
        chk("pause_no_wr", 32'(nwr), 32'd0);
        chk("pause_a_held", tr_a[4], 32'h0);
        chk("pause_resume_a", tr_a[6], 32'h1002);
        chk("pause_next_a", tr_a[7], 32'h1003);

        foreach (vt[i]) begin
            run(vt[i].is_if, vt[i].we, vt[i].size, vt[i].addr, vt[i].wdata, 0, 0, d, c);
            chk($sformatf("vec%0d_cyc", i), 32'(c), 32'(vt[i].exp_cyc));
            if (!vt[i].we) chk($sformatf("vec%0d_data", i), d, vt[i].exp_data);
        end

        // Wrapping word store, read back across the wrap.
        run(0, 1, 2'd2, 32'hFFFF_FFFE, 32'h0403_0201, 0, 0, d, c);
        chk("wrap_cyc", 32'(c), 32'd5);
        chk("wrap_a0", tr_a[0], 32'hFFFF_FFFE);
        chk("wrap_a1", tr_a[1], 32'hFFFF_FFFF);
        chk("wrap_a2", tr_a[2], 32'h0000_0000);
        chk("wrap_a3", tr_a[3], 32'h0000_0001);
        run(0, 0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 0, d, c);
        chk("wrap_rd", d, 32'h0403_0201);

        // IO byte store: exactly one write cycle.
        run(0, 1, 2'd0, 32'h0003_0000, 32'h0000_0041, 0, 0, d, c);
        nwr = 0;
        foreach (tr_wr[i]) nwr += int'(tr_wr[i]);
        chk("io_wr_count", 32'(nwr), 32'd1);
        chk("io_a", tr_a[0], 32'h0003_0000);
        chk("io_d", 32'(tr_dout[0]), 32'h41);

        // Asynchronous reset in the middle of a write.
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'd2;
        bus.ls_addr = 32'h5000; bus.ls_wdata = 32'h1234_5678;
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
        chk("midrst_wr_before", 32'(bus.mem_wr), 32'd1);
        #1;
        rst_in = 1'b1;
        #1;
        chk("midrst_wr",     32'(bus.mem_wr), 32'd0);
        chk("midrst_a",      bus.mem_a,      32'h0);
        chk("midrst_rdata",  bus.ls_rdata,   32'h0);
        chk("midrst_ifdata", bus.if_data,    32'h0);
        bus.ls_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        run(1, 0, 2'd2, 32'h1000, 32'h0, 0, 0, d, c);
        chk("post_rst_cyc",  32'(c), 32'd6);
        chk("post_rst_data", d, 32'h4433_2211);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
